// File: rtl/vec_reduce.sv
// Pipelined cross-lane reduction (SUM / MAX / SUMSQ) with per-packet accumulation.
// Define VEC_REDUCE_MEAN_EN to make op 3 a MEAN (sum divided by WIDTH*count); otherwise op 3 acts as SUM.
module vec_reduce #(
  parameter int WIDTH = 128
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  real         in_data [WIDTH-1:0],
  input  logic        in_last,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output real         out_data,
  output logic [15:0] out_count
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam logic [1:0] OP_MAX   = 2'd1;
  localparam logic [1:0] OP_SUMSQ = 2'd2;
`ifdef VEC_REDUCE_MEAN_EN
  localparam logic [1:0] OP_MEAN  = 2'd3;
`endif

  function automatic real combine(input real a, input real b, input logic [1:0] o);
    if (o == OP_MAX) return (a > b) ? a : b;
    return a + b;
  endfunction

  logic        stall;
  logic        accept;
  logic        pkt_active_reg;
  logic [1:0]  op_lat_reg;
  logic [1:0]  op_eff;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  // op is frozen from the first beat until the packet's last beat is taken
  assign op_eff   = pkt_active_reg ? op_lat_reg : op;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_active_reg <= 1'b0;
      op_lat_reg     <= 2'd0;
    end else if (accept) begin
      pkt_active_reg <= !in_last;
      op_lat_reg     <= op_eff;
    end
  end

  // Stage 0 registers the (optionally squared) lanes; stages 1..LOG2W halve the lane count.
  for (genvar gi = 0; gi <= LOG2W; gi++) begin : stg
    localparam int N = WIDTH >> gi;
    real        data_reg [N];
    logic       vld_reg;
    logic       lst_reg;
    logic [1:0] op_reg;

    if (gi == 0) begin : g_in
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          vld_reg <= 1'b0;
          lst_reg <= 1'b0;
          op_reg  <= 2'd0;
          for (int i = 0; i < N; i++) data_reg[i] <= 0.0;
        end else if (!stall) begin
          vld_reg <= accept;
          lst_reg <= in_last;
          op_reg  <= op_eff;
          for (int i = 0; i < N; i++)
            data_reg[i] <= (op_eff == OP_SUMSQ) ? in_data[i] * in_data[i] : in_data[i];
        end
      end
    end else begin : g_red
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          vld_reg <= 1'b0;
          lst_reg <= 1'b0;
          op_reg  <= 2'd0;
          for (int i = 0; i < N; i++) data_reg[i] <= 0.0;
        end else if (!stall) begin
          vld_reg <= stg[gi-1].vld_reg;
          lst_reg <= stg[gi-1].lst_reg;
          op_reg  <= stg[gi-1].op_reg;
          for (int i = 0; i < N; i++)
            data_reg[i] <= combine(stg[gi-1].data_reg[2*i], stg[gi-1].data_reg[2*i+1],
                                   stg[gi-1].op_reg);
        end
      end
    end
  end

  real         tree_val;
  logic        tree_vld;
  logic        tree_lst;
  logic [1:0]  tree_op;
  real         acc_reg;
  logic        acc_active_reg;
  logic [15:0] cnt_reg;
  real         acc_next;
  real         fin_val;
  logic [15:0] cnt_next;
  logic        out_valid_reg;
  real         out_data_reg;
  logic [15:0] out_count_reg;

  assign tree_val = stg[LOG2W].data_reg[0];
  assign tree_vld = stg[LOG2W].vld_reg;
  assign tree_lst = stg[LOG2W].lst_reg;
  assign tree_op  = stg[LOG2W].op_reg;

  // First beat loads the tree result directly so MAX is never seeded with 0.
  always_comb begin
    acc_next = tree_val;
    cnt_next = 16'd1;
    if (acc_active_reg) begin
      acc_next = combine(acc_reg, tree_val, tree_op);
      cnt_next = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
    end
    fin_val = acc_next;
`ifdef VEC_REDUCE_MEAN_EN
    if (tree_op == OP_MEAN)
      fin_val = acc_next / (real'(WIDTH) * real'(cnt_next));
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_active_reg <= 1'b0;
      acc_reg        <= 0.0;
      cnt_reg        <= 16'd0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= 0.0;
      out_count_reg  <= 16'd0;
    end else if (!stall) begin
      // not stalled means any pending result is being taken this cycle
      out_valid_reg <= 1'b0;
      if (tree_vld) begin
        if (tree_lst) begin
          out_data_reg   <= fin_val;
          out_count_reg  <= cnt_next;
          out_valid_reg  <= 1'b1;
          acc_active_reg <= 1'b0;
        end else begin
          acc_reg        <= acc_next;
          cnt_reg        <= cnt_next;
          acc_active_reg <= 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;

endmodule
